// File: rtl/alu_control_seq_pkg.sv
// Shared constants and types for the ALU control sequencer: ALU select codes,
// main-control opcodes, R-type funct values, FSM states and the decode record.
package alu_ctl_pkg;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_RTYPE = 2'b10;
   localparam logic [1:0] OP_ILL   = 2'b11;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ITER = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   typedef struct packed {
      logic [2:0] sel;
      logic       is_mul;
      logic       is_signed;
      logic       is_illegal;
   } dec_t;

endpackage

// File: rtl/alu_control_seq_decode.sv
// Combinational decode of alu_op/funct into ALU select plus multiply/illegal flags.
// Multiplies and illegal encodings report ALU_ADD as their select.
module alu_funct_decode
   import alu_ctl_pkg::*;
(
   input  logic [1:0] i_alu_op,
   input  logic [5:0] i_funct,
   output dec_t       o_dec
);

   always_comb begin
      o_dec = '{sel: ALU_ADD, is_mul: 1'b0, is_signed: 1'b0, is_illegal: 1'b0};
      case (i_alu_op)
         OP_ADD: o_dec.sel = ALU_ADD;
         OP_SUB: o_dec.sel = ALU_SUB;
         OP_RTYPE: begin
            case (i_funct)
               F_ADD:   o_dec.sel = ALU_ADD;
               F_SUB:   o_dec.sel = ALU_SUB;
               F_AND:   o_dec.sel = ALU_AND;
               F_OR:    o_dec.sel = ALU_OR;
               F_SLT:   o_dec.sel = ALU_SLT;
               F_MULT: begin
                  o_dec.is_mul    = 1'b1;
                  o_dec.is_signed = 1'b1;
               end
               F_MULTU: o_dec.is_mul = 1'b1;
               default: o_dec.is_illegal = 1'b1;
            endcase
         end
         OP_ILL:  o_dec.is_illegal = 1'b1;
         default: o_dec.is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control unit: single-cycle decode plus LOAD/ITER/WB sequencing
// of the shift-add multiplier. Handshake: start is accepted on an edge where ready=1.
module alu_control_seq
   import alu_ctl_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic             abort,
   output logic             ready,
   output logic [2:0]       alu_ctl,
   output logic             mul_load,
   output logic             mul_signed,
   output logic             mul_step,
   output logic [CNT_W-1:0] step_cnt,
   output logic             hilo_we,
   output logic             done,
   output logic             illegal,
   output state_t           dbg_state
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t           r_state, w_nxt_state;
   logic [2:0]       r_alu_ctl, w_nxt_alu_ctl;
   logic             r_mul_load, w_nxt_mul_load;
   logic             r_mul_signed, w_nxt_mul_signed;
   logic             r_mul_step, w_nxt_mul_step;
   logic [CNT_W-1:0] r_step_cnt, w_nxt_step_cnt;
   logic             r_hilo_we, w_nxt_hilo_we;
   logic             r_done, w_nxt_done;
   logic             r_illegal, w_nxt_illegal;
   dec_t             w_dec;

   alu_funct_decode u_decode (
      .i_alu_op (alu_op),
      .i_funct  (funct),
      .o_dec    (w_dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_alu_ctl    <= ALU_ADD;
         r_mul_load   <= 1'b0;
         r_mul_signed <= 1'b0;
         r_mul_step   <= 1'b0;
         r_step_cnt   <= '0;
         r_hilo_we    <= 1'b0;
         r_done       <= 1'b0;
         r_illegal    <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_alu_ctl    <= w_nxt_alu_ctl;
         r_mul_load   <= w_nxt_mul_load;
         r_mul_signed <= w_nxt_mul_signed;
         r_mul_step   <= w_nxt_mul_step;
         r_step_cnt   <= w_nxt_step_cnt;
         r_hilo_we    <= w_nxt_hilo_we;
         r_done       <= w_nxt_done;
         r_illegal    <= w_nxt_illegal;
      end
   end

   // Next values are computed one cycle ahead so every strobe leaves a flop.
   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_alu_ctl    = r_alu_ctl;
      w_nxt_mul_load   = 1'b0;
      w_nxt_mul_signed = r_mul_signed;
      w_nxt_mul_step   = 1'b0;
      w_nxt_step_cnt   = r_step_cnt;
      w_nxt_hilo_we    = 1'b0;
      w_nxt_done       = 1'b0;
      w_nxt_illegal    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (w_dec.is_mul) begin
                  w_nxt_state      = ST_LOAD;
                  w_nxt_alu_ctl    = ALU_ADD;
                  w_nxt_mul_signed = w_dec.is_signed;
                  w_nxt_mul_load   = 1'b1;
               end else begin
                  w_nxt_alu_ctl = w_dec.sel;
                  w_nxt_done    = 1'b1;
                  w_nxt_illegal = w_dec.is_illegal;
               end
            end
         end
         ST_LOAD: begin
            w_nxt_step_cnt = '0;
            if (abort) begin
               w_nxt_state      = ST_IDLE;
               w_nxt_mul_signed = 1'b0;
            end else begin
               w_nxt_state    = ST_ITER;
               w_nxt_mul_step = 1'b1;
            end
         end
         ST_ITER: begin
            if (abort) begin
               w_nxt_state      = ST_IDLE;
               w_nxt_mul_signed = 1'b0;
               w_nxt_step_cnt   = '0;
            end else if (r_step_cnt == LAST_STEP) begin
               // Leave before the counter could wrap; WB reports 0.
               w_nxt_state    = ST_WB;
               w_nxt_step_cnt = '0;
               w_nxt_hilo_we  = 1'b1;
               w_nxt_done     = 1'b1;
            end else begin
               w_nxt_mul_step = 1'b1;
               w_nxt_step_cnt = r_step_cnt + 1'b1;
            end
         end
         ST_WB: begin
            w_nxt_state      = ST_IDLE;
            w_nxt_mul_signed = 1'b0;
         end
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   assign ready      = (r_state == ST_IDLE);
   assign alu_ctl    = r_alu_ctl;
   assign mul_load   = r_mul_load;
   assign mul_signed = r_mul_signed;
   assign mul_step   = r_mul_step;
   assign step_cnt   = r_step_cnt;
   assign hilo_we    = r_hilo_we;
   assign done       = r_done;
   assign illegal    = r_illegal;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: a WIDTH=4 and a WIDTH=32 instance share one stimulus stream.
// Decode table, hand-written multiply/abort/reset sequences, then random traffic vs a model.
module tb_alu_control_seq;
   import alu_ctl_pkg::*;

   localparam int WA = 4;
   localparam int WB = 32;

   logic clk = 1'b0;
   logic rst_n;
   logic start, abort;
   logic [1:0] alu_op;
   logic [5:0] funct;

   logic ready_a, mul_load_a, mul_signed_a, mul_step_a, hilo_we_a, done_a, illegal_a;
   logic [2:0] alu_ctl_a;
   logic [1:0] step_cnt_a;
   state_t dbg_a;
   logic ready_b, mul_load_b, mul_signed_b, mul_step_b, hilo_we_b, done_b, illegal_b;
   logic [2:0] alu_ctl_b;
   logic [4:0] step_cnt_b;
   state_t dbg_b;

   int n_checks = 0;
   int n_fail = 0;

   alu_control_seq #(.WIDTH(WA)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .funct(funct), .abort(abort),
      .ready(ready_a), .alu_ctl(alu_ctl_a), .mul_load(mul_load_a), .mul_signed(mul_signed_a),
      .mul_step(mul_step_a), .step_cnt(step_cnt_a), .hilo_we(hilo_we_a), .done(done_a),
      .illegal(illegal_a), .dbg_state(dbg_a));

   alu_control_seq #(.WIDTH(WB)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .funct(funct), .abort(abort),
      .ready(ready_b), .alu_ctl(alu_ctl_b), .mul_load(mul_load_b), .mul_signed(mul_signed_b),
      .mul_step(mul_step_b), .step_cnt(step_cnt_b), .hilo_we(hilo_we_b), .done(done_b),
      .illegal(illegal_b), .dbg_state(dbg_b));

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Inputs change at negedge; one call moves to the next negedge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic s, input logic [1:0] op, input logic [5:0] fn, input logic ab);
      start = s; alu_op = op; funct = fn; abort = ab;
   endtask

   task automatic do_reset();
      drive(0, 2'b00, 6'd0, 0);
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready_a"}, ready_a, 1);       check({tag, "_alu_a"}, alu_ctl_a, 3'b010);
      check({tag, "_load_a"}, mul_load_a, 0);     check({tag, "_sgn_a"}, mul_signed_a, 0);
      check({tag, "_step_a"}, mul_step_a, 0);     check({tag, "_cnt_a"}, step_cnt_a, 0);
      check({tag, "_hilo_a"}, hilo_we_a, 0);      check({tag, "_done_a"}, done_a, 0);
      check({tag, "_ill_a"}, illegal_a, 0);
      check({tag, "_ready_b"}, ready_b, 1);       check({tag, "_alu_b"}, alu_ctl_b, 3'b010);
      check({tag, "_step_b"}, mul_step_b, 0);     check({tag, "_cnt_b"}, step_cnt_b, 0);
      check({tag, "_done_b"}, done_b, 0);         check({tag, "_sgn_b"}, mul_signed_b, 0);
   endtask

   // Reference classification taken straight from the decode rules.
   function automatic void classify(input logic [1:0] op, input logic [5:0] fn,
                                    output logic [2:0] sel, output bit mul, output bit sgn,
                                    output bit ill);
      sel = 3'b010; mul = 0; sgn = 0; ill = 0;
      if (op == 2'b00) sel = 3'b010;
      else if (op == 2'b01) sel = 3'b110;
      else if (op == 2'b10) begin
         if (fn == 6'b100000) sel = 3'b010;
         else if (fn == 6'b100010) sel = 3'b110;
         else if (fn == 6'b100100) sel = 3'b000;
         else if (fn == 6'b100101) sel = 3'b001;
         else if (fn == 6'b101010) sel = 3'b111;
         else if (fn == 6'b011000) begin mul = 1; sgn = 1; end
         else if (fn == 6'b011001) mul = 1;
         else ill = 1;
      end else ill = 1;
   endfunction

   // Model: m_k = cycles elapsed since a multiply was accepted (0 = idle).
   int m_k;
   logic [2:0] m_alu;
   bit m_sgn;
   bit e_load, e_step, e_hwe, e_done, e_ill;
   int e_cnt;
   logic [2:0] exp_q[$];

   task automatic model_step(input logic s, input logic [1:0] op, input logic [5:0] fn,
                             input logic ab);
      logic [2:0] sel;
      bit mul, sgn, ill;
      e_load = 0; e_step = 0; e_hwe = 0; e_done = 0; e_ill = 0; e_cnt = 0;
      if (m_k == 0) begin
         if (s) begin
            classify(op, fn, sel, mul, sgn, ill);
            if (mul) begin
               m_k = 1; m_alu = 3'b010; m_sgn = sgn; e_load = 1;
            end else begin
               m_alu = sel; e_done = 1; e_ill = ill;
            end
         end
      end else if (m_k <= WA + 1 && ab) begin
         m_k = 0; m_sgn = 0;
      end else if (m_k == WA + 2) begin
         m_k = 0; m_sgn = 0;
      end else begin
         m_k++;
         if (m_k <= WA + 1) begin e_step = 1; e_cnt = m_k - 2; end
         else begin e_hwe = 1; e_done = 1; end
      end
      if (e_done) exp_q.push_back(m_alu);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [5:0] fn;
      logic [2:0] exp_alu;
      logic       exp_ill;
   } vec_t;

   vec_t vecs[11];
   logic [5:0] fn_tab[7];
   logic [2:0] got;
   int n, steps;

   initial begin
      vecs[0]  = '{2'b00, 6'b000000, 3'b010, 1'b0};
      vecs[1]  = '{2'b10, 6'b100000, 3'b010, 1'b0};
      vecs[2]  = '{2'b10, 6'b100010, 3'b110, 1'b0};
      vecs[3]  = '{2'b10, 6'b100100, 3'b000, 1'b0};
      vecs[4]  = '{2'b10, 6'b100101, 3'b001, 1'b0};
      vecs[5]  = '{2'b10, 6'b101010, 3'b111, 1'b0};
      vecs[6]  = '{2'b10, 6'b000111, 3'b010, 1'b1};
      vecs[7]  = '{2'b01, 6'b000000, 3'b110, 1'b0};
      vecs[8]  = '{2'b11, 6'b100100, 3'b010, 1'b1};
      vecs[9]  = '{2'b01, 6'b011000, 3'b110, 1'b0};
      vecs[10] = '{2'b00, 6'b011001, 3'b010, 1'b0};
      fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000, 6'b011001};

      // reset values while held
      drive(0, 2'b00, 6'd0, 0);
      rst_n = 1'b0;
      cyc();
      check_reset_vals("rst");
      rst_n = 1'b1;
      cyc();

      // back-to-back decode table, one request per cycle
      for (int i = 0; i < 11; i++) begin
         drive(1, vecs[i].op, vecs[i].fn, 0);
         cyc();
         check($sformatf("tab%0d_alu", i), alu_ctl_a, vecs[i].exp_alu);
         check($sformatf("tab%0d_done", i), done_a, 1);
         check($sformatf("tab%0d_ill", i), illegal_a, vecs[i].exp_ill);
         check($sformatf("tab%0d_ready", i), ready_a, 1);
         check($sformatf("tab%0d_alu_b", i), alu_ctl_b, vecs[i].exp_alu);
      end
      drive(0, 2'b00, 6'd0, 0);
      cyc();
      check("idle_done", done_a, 0);
      check("idle_ill", illegal_a, 0);
      check("idle_alu_hold", alu_ctl_a, 3'b010);

      // mult on WIDTH=4; a start in cycle 3 must be ignored
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         drive(1, 2'b10, pass == 0 ? 6'b011000 : 6'b011001, 0);
         cyc();
         drive(0, 2'b00, 6'd0, 0);
         check($sformatf("m%0d_load", pass), mul_load_a, 1);
         check($sformatf("m%0d_sgn_load", pass), mul_signed_a, pass == 0);
         check($sformatf("m%0d_ready_load", pass), ready_a, 0);
         check($sformatf("m%0d_step_load", pass), mul_step_a, 0);
         for (int i = 0; i < WA; i++) begin
            cyc();
            check($sformatf("m%0d_step%0d", pass, i), mul_step_a, 1);
            check($sformatf("m%0d_cnt%0d", pass, i), step_cnt_a, i);
            check($sformatf("m%0d_load%0d", pass, i), mul_load_a, 0);
            check($sformatf("m%0d_done%0d", pass, i), done_a, 0);
            check($sformatf("m%0d_hilo%0d", pass, i), hilo_we_a, 0);
            check($sformatf("m%0d_ready%0d", pass, i), ready_a, 0);
            if (i == 1) drive(1, 2'b01, 6'd0, 0);
            else drive(0, 2'b00, 6'd0, 0);
         end
         cyc();
         check($sformatf("m%0d_wb_hilo", pass), hilo_we_a, 1);
         check($sformatf("m%0d_wb_done", pass), done_a, 1);
         check($sformatf("m%0d_wb_step", pass), mul_step_a, 0);
         check($sformatf("m%0d_wb_sgn", pass), mul_signed_a, pass == 0);
         check($sformatf("m%0d_wb_alu", pass), alu_ctl_a, 3'b010);
         check($sformatf("m%0d_wb_ill", pass), illegal_a, 0);
         cyc();
         check($sformatf("m%0d_end_ready", pass), ready_a, 1);
         check($sformatf("m%0d_end_done", pass), done_a, 0);
         check($sformatf("m%0d_end_hilo", pass), hilo_we_a, 0);
      end

      // abort at step_cnt=2
      do_reset();
      drive(1, 2'b10, 6'b011000, 0);
      cyc();
      drive(0, 2'b00, 6'd0, 0);
      cyc(); cyc(); cyc();
      check("ab_cnt2", step_cnt_a, 2);
      drive(0, 2'b00, 6'd0, 1);
      cyc();
      drive(0, 2'b00, 6'd0, 0);
      check("ab_ready", ready_a, 1);
      check("ab_step", mul_step_a, 0);
      check("ab_cnt", step_cnt_a, 0);
      check("ab_done", done_a, 0);
      check("ab_hilo", hilo_we_a, 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check($sformatf("ab_after%0d_done", i), done_a, 0);
         check($sformatf("ab_after%0d_hilo", i), hilo_we_a, 0);
      end

      // reset asserted during ITER takes effect without a clock edge
      drive(1, 2'b10, 6'b011000, 0);
      cyc();
      drive(0, 2'b00, 6'd0, 0);
      cyc(); cyc();
      check("pre_rst_step", mul_step_a, 1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("async");
      cyc(); cyc();
      check("rst_hold_done", done_a, 0);
      rst_n = 1'b1;
      cyc();

      // WIDTH=32 multu: done 33 edges after acceptance, abort in WB ignored
      drive(1, 2'b10, 6'b011001, 0);
      cyc();
      drive(0, 2'b00, 6'd0, 0);
      n = 1; steps = 0;
      check("w32_load", mul_load_b, 1);
      check("w32_sgn", mul_signed_b, 0);
      while (done_b !== 1'b1 && n < 100) begin
         if (mul_step_b === 1'b1) steps++;
         cyc();
         n++;
      end
      check("w32_done_latency", n - 1, 33);
      check("w32_steps", steps, WB);
      check("w32_hilo", hilo_we_b, 1);
      drive(0, 2'b00, 6'd0, 1);
      cyc();
      drive(0, 2'b00, 6'd0, 0);
      check("w32_ready", ready_b, 1);
      check("w32_done_clr", done_b, 0);

      // random traffic on WIDTH=4 against the model
      do_reset();
      m_k = 0; m_alu = 3'b010; m_sgn = 0;
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         int r, k;
         r = $urandom_range(0, 7);
         k = $urandom_range(0, 7);
         start = ($urandom_range(0, 1) == 1);
         alu_op = (r < 4) ? 2'b10 : 2'(r - 4);
         funct = (k == 7) ? 6'($urandom_range(0, 63)) : fn_tab[k];
         abort = ($urandom_range(0, 7) == 0);
         @(posedge clk);
         model_step(start, alu_op, funct, abort);
         @(negedge clk);
         check("rnd_ready", ready_a, m_k == 0);
         check("rnd_load", mul_load_a, e_load);
         check("rnd_step", mul_step_a, e_step);
         if (e_step) check("rnd_cnt", step_cnt_a, e_cnt);
         check("rnd_hilo", hilo_we_a, e_hwe);
         check("rnd_done", done_a, e_done);
         check("rnd_ill", illegal_a, e_ill);
         check("rnd_alu", alu_ctl_a, m_alu);
         if (m_k != 0) check("rnd_sgn", mul_signed_a, m_sgn);
         if (done_a === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL sb_unexpected_done: got done=1 expected no done");
            end else begin
               got = exp_q.pop_front();
               check("sb_alu", alu_ctl_a, got);
            end
         end
      end
      check("sb_drain", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
